// File: rtl/miner_pkg.sv
// Shared types and defaults for the multi-core nonce dispatcher.
package miner_pkg;

    localparam int DEF_NONCE_W = 32;
    localparam int DEF_HASH_W  = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FOUND,
        EXHAUSTED
    } dispState_t;

    function automatic logic [4:0] popCount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/lane_compare.sv
// Per-core hash check: strict unsigned less-than of a returned hash against the latched target.
module lane_compare #(
    parameter int HASH_W = 256
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              lessThan
);

    // Equal is a miss: only a strictly smaller hash wins.
    assign lessThan = (hash < target);

endmodule

// File: rtl/mining_dispatcher.sv
// Multi-core nonce dispatcher: hands consecutive nonces to SHA cores and reports the first winner.
// Defining DISPATCH_STATS_EN adds the hashes_checked counter output.
//   state     | meaning
//   IDLE      | waiting for start
//   RUN       | dispatching nonces, checking returned hashes
//   FOUND     | winning nonce held until ack
//   EXHAUSTED | whole nonce space tried without a hit, held until ack
module mining_dispatcher
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = DEF_NONCE_W,
    parameter int HASH_W    = DEF_HASH_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         ack,
    input  logic [NONCE_W-1:0]           nonce_base,
    input  logic [HASH_W-1:0]            target,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES*HASH_W-1:0]  core_hash,
    output logic                         busy,
    output logic                         found_valid,
    output logic [NONCE_W-1:0]           found_nonce,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]                  hashes_checked,
`endif
    output logic                         exhausted
);

    dispState_t           state, stateNext;
    logic [HASH_W-1:0]    targetLatched;
    logic [NONCE_W-1:0]   nextNonce;
    logic                 issuedAll;
    logic [NUM_CORES-1:0] coreBusy;
    logic [NUM_CORES-1:0] accepted;
    logic [NUM_CORES-1:0] laneLess;
    logic [NUM_CORES-1:0] hitVec;
    logic [NUM_CORES-1:0] freeFirst;
    logic [NUM_CORES-1:0] dispatchVec;
    logic [NUM_CORES-1:0] busyAfter;
    logic                 anyHit;
    logic                 canDispatch;
    logic                 exhaustNow;
    logic                 startRun;
    logic [NONCE_W-1:0]   winNonce;

    for (genvar i = 0; i < NUM_CORES; i++) begin : gLane
        lane_compare #(
            .HASH_W(HASH_W)
        ) uCompare (
            .hash    (core_hash[i*HASH_W +: HASH_W]),
            .target  (targetLatched),
            .lessThan(laneLess[i])
        );
    end

    // Completions only count in RUN and only from cores we actually launched.
    assign accepted    = (state == RUN) ? (core_done & coreBusy) : '0;
    assign hitVec      = accepted & laneLess;
    assign anyHit      = |hitVec;
    assign canDispatch = (state == RUN) && !issuedAll && !anyHit && !abort;
    assign startRun    = (state == IDLE) && start && !abort;

    always_comb begin
        freeFirst = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!coreBusy[i]) begin
                freeFirst    = '0;
                freeFirst[i] = 1'b1;
            end
        end
    end

    always_comb begin
        winNonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hitVec[i]) winNonce = core_nonce[i*NONCE_W +: NONCE_W];
        end
    end

    // Uses the registered busy mask, so a core finishing this edge is reused next edge at the earliest.
    assign dispatchVec = canDispatch ? freeFirst : '0;
    assign busyAfter   = (coreBusy & ~accepted) | dispatchVec;
    assign exhaustNow  = issuedAll && (busyAfter == '0) && !anyHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        busy        = 1'b0;
        found_valid = 1'b0;
        exhausted   = 1'b0;
        case (state)
            IDLE: begin
                if (startRun) stateNext = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)           stateNext = IDLE;
                else if (anyHit)     stateNext = FOUND;
                else if (exhaustNow) stateNext = EXHAUSTED;
            end
            FOUND: begin
                found_valid = 1'b1;
                if (abort || ack) stateNext = IDLE;
            end
            EXHAUSTED: begin
                exhausted = 1'b1;
                if (abort || ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            targetLatched <= '0;
            nextNonce     <= '0;
            issuedAll     <= 1'b0;
            coreBusy      <= '0;
            core_start    <= '0;
            core_nonce    <= '0;
            found_nonce   <= '0;
        end else begin
            core_start <= dispatchVec;
            if (abort) begin
                coreBusy <= '0;
            end else if (startRun) begin
                targetLatched <= target;
                nextNonce     <= nonce_base;
                issuedAll     <= 1'b0;
                coreBusy      <= '0;
            end else if (state == RUN) begin
                // After a hit the remaining cores drain unobserved.
                coreBusy <= anyHit ? '0 : busyAfter;
                if (anyHit) found_nonce <= winNonce;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (dispatchVec[i]) core_nonce[i*NONCE_W +: NONCE_W] <= nextNonce;
            end
            // The wrapped value after all-ones is never launched.
            if (|dispatchVec) begin
                nextNonce <= nextNonce + NONCE_W'(1);
                if (&nextNonce) issuedAll <= 1'b1;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] acceptedWide;
    logic [32:0] statsSum;

    always_comb begin
        acceptedWide                = '0;
        acceptedWide[NUM_CORES-1:0] = accepted;
    end

    assign statsSum = {1'b0, hashes_checked} + 33'(popCount16(acceptedWide));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         hashes_checked <= '0;
        else if (startRun)               hashes_checked <= '0;
        else if (state == RUN && !abort) hashes_checked <= statsSum[32] ? '1 : statsSum[31:0];
    end
`endif

endmodule

// File: tb/tb_mining_dispatcher.sv
// Bench for mining_dispatcher: table of search runs driven by emulated SHA cores and a nonce-level model.
`timescale 1ns/1ps
module tb_mining_dispatcher;
    import miner_pkg::*;

    localparam int NC = 4;
    localparam int NW = 32;
    localparam int HW = 256;
    localparam int OUT_FOUND = 0;
    localparam int OUT_EXH   = 1;
    localparam int OUT_ABORT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, abort, ack;
    logic [NW-1:0]    nonce_base;
    logic [HW-1:0]    target;
    logic [NC-1:0]    core_start, core_done;
    logic [NC*NW-1:0] core_nonce;
    logic [NC*HW-1:0] core_hash;
    logic             busy, found_valid, exhausted;
    logic [NW-1:0]    found_nonce;
`ifdef DISPATCH_STATS_EN
    logic [31:0]      hashes_checked;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    mining_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .ack        (ack),
        .nonce_base (nonce_base),
        .target     (target),
        .core_start (core_start),
        .core_nonce (core_nonce),
        .core_done  (core_done),
        .core_hash  (core_hash),
        .busy       (busy),
        .found_valid(found_valid),
        .found_nonce(found_nonce),
`ifdef DISPATCH_STATS_EN
        .hashes_checked(hashes_checked),
`endif
        .exhausted  (exhausted)
    );

    typedef struct {
        logic [31:0] base;
        int          latMin, latMax, alignAt;
        int          nWin;
        logic [31:0] win0, win1;
        logic        eqMode;
        int          abortAt;
        logic        chkNonce;
        logic [31:0] expNonce;
        int          expStarts;
    } run_t;

    run_t runs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic run_t mkRow(input logic [31:0] base, input int latMin, input int latMax,
                                   input int alignAt, input int nWin, input logic [31:0] win0,
                                   input logic [31:0] win1, input logic eqMode, input int abortAt,
                                   input logic chkNonce, input logic [31:0] expNonce, input int expStarts);
        run_t r;
        r.base = base; r.latMin = latMin; r.latMax = latMax; r.alignAt = alignAt;
        r.nWin = nWin; r.win0 = win0; r.win1 = win1; r.eqMode = eqMode; r.abortAt = abortAt;
        r.chkNonce = chkNonce; r.expNonce = expNonce; r.expStarts = expStarts;
        return r;
    endfunction

    function automatic logic isWin(input run_t r, input logic [31:0] n);
        return (r.nWin >= 1 && n == r.win0) || (r.nWin >= 2 && n == r.win1);
    endfunction

    function automatic logic [HW-1:0] hashFor(input run_t r, input logic [31:0] n, input logic [HW-1:0] tgt);
        if (isWin(r, n)) return tgt - HW'(1 + $urandom_range(0, 1000));
        if (r.eqMode)    return tgt;
        return tgt + HW'(1 + $urandom_range(0, 1000));
    endfunction

    task automatic runOne(input run_t r);
        logic [HW-1:0] tgt;
        logic [32:0]   expNext;
        logic [31:0]   job[NC];
        logic [31:0]   winner;
        logic          freeDut[NC];
        logic [2:0]    expFlags;
        int            remain[NC];
        int            starts, accCnt, outcome, cyc;
        for (int k = 0; k < HW / 32; k++) tgt[k*32 +: 32] = $urandom;
        tgt[255:248] = 8'h00;
        tgt[200]     = 1'b1;
        for (int i = 0; i < NC; i++) begin remain[i] = -1; freeDut[i] = 1'b1; job[i] = '0; end
        starts = 0; accCnt = 0; outcome = -1; winner = '0;
        expNext    = {1'b0, r.base};
        nonce_base = r.base;
        target     = tgt;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {busy, found_valid, exhausted}, 3'b100);
        for (cyc = 1; cyc <= 400 && outcome < 0; cyc++) begin
            logic hit, doAbort, allFree;
            logic [31:0] w;
            int expCore;
            hit = 1'b0; w = '0; expCore = -1;
            doAbort = (cyc == r.abortAt);
            core_done = '0;
            for (int i = 0; i < NC; i++) begin
                if (remain[i] == 0) begin
                    core_done[i] = 1'b1;
                    core_hash[i*HW +: HW] = hashFor(r, job[i], tgt);
                    if (!doAbort) accCnt++;
                    if (!hit && isWin(r, job[i])) begin hit = 1'b1; w = job[i]; end
                end
            end
            if (!doAbort && !hit && expNext <= 33'h0_FFFF_FFFF)
                for (int i = NC - 1; i >= 0; i--) if (freeDut[i]) expCore = i;
            abort = doAbort;
            tick();
            abort = 1'b0;
            core_done = '0;
            if (expCore >= 0) begin
                check("dispatch_core", 64'(core_start), 64'(1) << expCore);
                check("dispatch_nonce", 64'(core_nonce[expCore*NW +: NW]), 64'(expNext[31:0]));
            end else begin
                check("no_dispatch", 64'(core_start), 64'(0));
            end
            for (int i = 0; i < NC; i++) if (remain[i] == 0) begin remain[i] = -1; freeDut[i] = 1'b1; end
            if (expCore >= 0) begin
                job[expCore]     = expNext[31:0];
                freeDut[expCore] = 1'b0;
                remain[expCore]  = (r.alignAt > 0) ? ((r.alignAt - cyc > 1) ? r.alignAt - cyc : 1)
                                                   : int'($urandom_range(r.latMin, r.latMax));
                expNext++;
                starts++;
            end
            for (int i = 0; i < NC; i++) if (remain[i] > 0) remain[i]--;
            allFree = 1'b1;
            for (int i = 0; i < NC; i++) if (!freeDut[i]) allFree = 1'b0;
            if (doAbort)                                   outcome = OUT_ABORT;
            else if (hit) begin outcome = OUT_FOUND; winner = w; end
            else if (expNext > 33'h0_FFFF_FFFF && allFree) outcome = OUT_EXH;
            else check("run_flags", {busy, found_valid, exhausted}, 3'b100);
        end
        if (outcome < 0) begin
            nCompared++; nMismatched++;
            $display("FAIL run_timeout: no result after %0d cycles, base 0x%0h", cyc, r.base);
            return;
        end
        expFlags = (outcome == OUT_FOUND) ? 3'b010 : (outcome == OUT_EXH) ? 3'b001 : 3'b000;
        check("result_flags", {busy, found_valid, exhausted}, expFlags);
        if (outcome == OUT_FOUND) check("found_nonce", found_nonce, winner);
        if (outcome == OUT_FOUND && r.chkNonce) check("found_nonce_tbl", found_nonce, r.expNonce);
        if (r.expStarts >= 0) check("start_count", starts, r.expStarts);
        for (int d = 0; d < 12; d++) begin
            for (int i = 0; i < NC; i++) begin
                if (remain[i] == 0) begin
                    core_done[i] = 1'b1;
                    core_hash[i*HW +: HW] = hashFor(r, job[i], tgt);
                    remain[i] = -1;
                end
            end
            start = (d == 3 && outcome != OUT_ABORT);
            tick();
            start = 1'b0;
            core_done = '0;
            check("drain_no_start", 64'(core_start), 64'(0));
            check("drain_flags", {busy, found_valid, exhausted}, expFlags);
            for (int i = 0; i < NC; i++) if (remain[i] > 0) remain[i]--;
        end
        if (outcome == OUT_FOUND) check("found_held", found_nonce, winner);
`ifdef DISPATCH_STATS_EN
        check("hashes_checked", hashes_checked, accCnt);
`endif
        if (outcome != OUT_ABORT) begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("ack_clear", {busy, found_valid, exhausted}, 3'b000);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
        nonce_base = '0; target = '0; core_done = '0; core_hash = '0;
        runs[0] = mkRow(32'h100, 10, 10, 0, 1, 32'h105, 0, 1'b0, -1, 1'b1, 32'h105, -1);
        runs[1] = mkRow(32'hFFFF_FFFD, 3, 7, 0, 0, 0, 0, 1'b0, -1, 1'b0, 0, 3);
        runs[2] = mkRow(32'h10, 1, 1, 8, 2, 32'h11, 32'h13, 1'b0, -1, 1'b1, 32'h11, 4);
        runs[3] = mkRow(32'h200, 2, 5, 0, 1, 32'h207, 0, 1'b1, -1, 1'b1, 32'h207, -1);
        runs[4] = mkRow(32'h300, 20, 20, 0, 0, 0, 0, 1'b0, 6, 1'b0, 0, 4);
        for (int k = 5; k < 13; k++) begin
            b = $urandom_range(0, 32'hFFFE_0000);
            case (k % 4)
                0: runs[k] = mkRow(b, 1, 12, 0, 1, b + $urandom_range(0, 15), 0, 1'b0, -1, 1'b1,
                                   32'h0, -1);
                1: runs[k] = mkRow(b, 1, 12, 0, 2, b + $urandom_range(0, 15), b + $urandom_range(0, 15),
                                   $urandom_range(0, 1) == 1, -1, 1'b0, 0, -1);
                2: begin
                    b = 32'hFFFF_FFFF - $urandom_range(0, 9);
                    runs[k] = mkRow(b, 1, 9, 0, 0, 0, 0, 1'b0, -1, 1'b0, 0, int'(32'hFFFF_FFFF - b) + 1);
                end
                default: runs[k] = mkRow(b, 3, 15, 0, 0, 0, 0, 1'b0, $urandom_range(2, 12), 1'b0, 0, -1);
            endcase
            if (k % 4 == 0) runs[k].expNonce = runs[k].win0;
        end

        #12;
        check("rst_core_start", 64'(core_start), 64'(0));
        check("rst_core_nonce", 64'(core_nonce[63:0]) | 64'(core_nonce[127:64]), 64'(0));
        check("rst_flags", {busy, found_valid, exhausted}, 3'b000);
        check("rst_found_nonce", found_nonce, 32'h0);
        rst = 1'b0;
        tick();

        foreach (runs[k]) runOne(runs[k]);

        // Reset between edges in the middle of a search, then restart from a new base.
        nonce_base = 32'h500; target = {8'h00, {31{8'hA5}}};
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_core_start", 64'(core_start), 64'(0));
        check("midrst_core_nonce", 64'(core_nonce[63:0]) | 64'(core_nonce[127:64]), 64'(0));
        check("midrst_flags", {busy, found_valid, exhausted}, 3'b000);
        #1 rst = 1'b0;
        tick();
        nonce_base = 32'h600;
        start = 1'b1; tick(); start = 1'b0;
        check("restart_busy", {busy, found_valid, exhausted}, 3'b100);
        tick();
        check("restart_core", 64'(core_start), 64'(1));
        check("restart_nonce", 64'(core_nonce[31:0]), 64'(32'h600));
        abort = 1'b1; tick(); abort = 1'b0;
        check("restart_abort", {busy, found_valid, exhausted}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mining_dispatcher.md
# mining_dispatcher

Parametrised multi-core nonce dispatcher for the bitcoin miner: replaces the single-core controller/nonce-generator/comparator path with a block that feeds up to NUM_CORES SHA cores in parallel. It allocates consecutive nonces from a programmed base, checks every returned hash against the target, and reports the first winning nonce or search exhaustion. Sits between the Avalon CSR slave (base, target, start/ack) and the array of SHA computational blocks.

## Interface
- NUM_CORES, 4, number of SHA cores driven (1..16)
- NONCE_W, 32, nonce width
- HASH_W, 256, hash/target width
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse: begin search (ignored unless IDLE)
- abort  in  1  cancel search, return to IDLE
- ack  in  1  clears found/exhausted result, returns to IDLE
- nonce_base  in  NONCE_W  first nonce; sampled on start
- target  in  HASH_W  threshold; sampled on start
- core_start  out  NUM_CORES  one-cycle launch pulse per core
- core_nonce  out  NUM_CORES*NONCE_W  nonce for core i at slice i
- core_done  in  NUM_CORES  one-cycle completion pulse per core
- core_hash  in  NUM_CORES*HASH_W  hash from core i, valid with core_done[i]
- busy  out  1  high in RUN
- found_valid  out  1  winning nonce held
- found_nonce  out  NONCE_W  winning nonce
- exhausted  out  1  all nonces tried, no hit

## Operation
- States: IDLE, RUN, FOUND, EXHAUSTED.
- IDLE: start -> RUN; target latched, next_nonce <= nonce_base, issued_all cleared.
- RUN, per edge: lowest-index idle core (core_busy[i]=0) with issued_all=0 gets core_start[i]<=1, core_nonce[i]<=next_nonce, core_busy[i]<=1, next_nonce++. At most one dispatch per cycle.
- Issuing nonce all-ones sets issued_all; next_nonce wraps to 0 but is never dispatched.
- core_done[i] with core_busy[i]=1: clear core_busy[i]; hit = core_hash[i] < latched target (unsigned, strict; equal is a miss). core_done on an idle core is ignored.
- Any hit -> FOUND; found_nonce <= core_nonce of lowest-index hitting core; no further dispatch; remaining core_done ignored (cores drain).
- issued_all, all core_busy clear, no hit this edge -> EXHAUSTED. Hit beats exhaustion on same edge.
- FOUND/EXHAUSTED: outputs held until ack -> IDLE (flags clear on that edge).
- abort in any state -> IDLE, core_busy cleared, flags cleared, pending core_done ignored. abort beats ack, start, and hit on same edge.
- core_done and dispatch to the same core on one edge: core may be re-dispatched only on the following edge.

## Timing
- Reset: state IDLE; core_start, core_nonce, busy, found_valid, found_nonce, exhausted, next_nonce, core_busy all 0.
- start at edge 0 -> busy=1 after edge 0; core 0 launched at edge 1 (nonce=base), core k at edge 1+k while idle cores remain.
- core_start is registered, high exactly one cycle.
- Hit sampled at edge k -> found_valid=1, busy=0 after edge k (1-cycle latency).
- Last miss sampled at edge k -> exhausted=1 after edge k.
- rst mid-search: all outputs to reset values immediately, no result reported.

## Configuration
- DISPATCH_STATS_EN defined: adds output hashes_checked (32 bits), counting accepted core_done events; cleared on start, saturates at all-ones, holds in FOUND/EXHAUSTED, reset to 0.
- Not defined: port and counter absent; other behaviour identical.

## Structure
- Shared package miner_pkg: dispatch state enum (IDLE, RUN, FOUND, EXHAUSTED), default NONCE_W/HASH_W localparams.
- One sub-module: lane_compare (HASH_W-parametrised strict unsigned less-than of hash vs target), one instance per core; priority select and FSM in mining_dispatcher.

## Test plan
- NUM_CORES=4, base=0x100, cores done 10 cycles after start, only nonce 0x105 returns hash < target -> found_valid=1, found_nonce=0x105, no core_start after hit, ack returns IDLE.
- base=0xFFFFFFFD, all misses -> exactly 3 core_start pulses (FD, FE, FF), exhausted=1 one cycle after last core_done, no nonce 0 issued.
- Cores 1 (0x11) and 3 (0x13) hit on same edge -> found_nonce=0x11.
- core_hash equal to target -> miss; search continues.
- abort during RUN with 4 cores busy -> busy=0 next cycle, no flags; later core_done pulses produce no response.
- rst asserted mid-RUN between edges -> all outputs 0 before next edge; start afterwards restarts from new base.
